// File: rtl/vend_controller.sv
// Multi-slot vending controller: shared nickel-unit credit register, selection arbitration, dispense strobe and change payout.
// Optional per-slot stock counters are built when VEND_INVENTORY_EN is defined.
module vend_controller #(
   parameter int NUM_ITEMS  = 4,
   parameter int CREDIT_W   = 6,
   parameter int PRICE0     = 3,
   parameter int PRICE1     = 4,
   parameter int PRICE2     = 5,
   parameter int PRICE3     = 6,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 8
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                nickel_in,
   input  logic                dime_in,
   input  logic                cancel,
   input  logic                sel_valid,
   input  logic [1:0]          sel_item,
   input  logic                restock,
   output logic                dispense,
   output logic [1:0]          dispense_item,
   output logic                nickel_out,
   output logic                coin_reject,
   output logic                deny,
   output logic                busy,
   output logic [CREDIT_W-1:0] credit,
   output logic [3:0]          sold_out
);

   typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_t;

   localparam logic [CREDIT_W-1:0] ONE = CREDIT_W'(1);
   localparam logic [CREDIT_W-1:0] TWO = CREDIT_W'(2);

   state_t              state_reg, state_next;
   logic [CREDIT_W-1:0] credit_reg, credit_next;
   logic                dispense_reg, dispense_next;
   logic [1:0]          item_reg, item_next;
   logic                nickel_reg, nickel_next;
   logic                reject_reg, reject_next;
   logic                deny_reg, deny_next;
   logic                busy_reg;
   logic                accept;
   logic                sel_ok;
   logic [CREDIT_W:0]   sum_n, sum_d;
   logic [CREDIT_W-1:0] price_tbl [4];
   logic [3:0]          sold_out_int;

   assign price_tbl[0] = CREDIT_W'(PRICE0);
   assign price_tbl[1] = CREDIT_W'(PRICE1);
   assign price_tbl[2] = CREDIT_W'(PRICE2);
   assign price_tbl[3] = CREDIT_W'(PRICE3);

   assign sum_n  = {1'b0, credit_reg} + {1'b0, ONE};
   assign sum_d  = {1'b0, credit_reg} + {1'b0, TWO};
   assign sel_ok = ({1'b0, sel_item} < 3'(NUM_ITEMS)) &&
                   (credit_reg >= price_tbl[sel_item]) &&
                   !sold_out_int[sel_item];

`ifdef VEND_INVENTORY_EN
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_stock
         if (gi < NUM_ITEMS) begin : g_slot
            logic [STOCK_W-1:0] stock_reg;
            // Reload beats a same-edge decrement; accept never fires on an empty slot.
            always_ff @(posedge clock) begin
               if (!reset_n || restock)
                  stock_reg <= STOCK_W'(STOCK_INIT);
               else if (accept && (sel_item == 2'(gi)))
                  stock_reg <= stock_reg - STOCK_W'(1);
            end
            assign sold_out_int[gi] = (stock_reg == '0);
         end else begin : g_none
            assign sold_out_int[gi] = 1'b0;
         end
      end
   endgenerate
`else
   logic unused_inventory;
   assign unused_inventory = restock ^ (STOCK_W > 0) ^ (STOCK_INIT > 0);
   assign sold_out_int     = 4'b0000;
`endif

   always_comb begin
      state_next    = state_reg;
      credit_next   = credit_reg;
      dispense_next = 1'b0;
      item_next     = 2'd0;
      nickel_next   = 1'b0;
      reject_next   = 1'b0;
      deny_next     = 1'b0;
      accept        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cancel) begin
               reject_next = nickel_in | dime_in;
               if (credit_reg != '0) begin
                  state_next  = CHANGE;
                  credit_next = credit_reg - ONE;
                  nickel_next = 1'b1;
               end
            end else if (sel_valid && sel_ok) begin
               accept        = 1'b1;
               state_next    = VEND;
               credit_next   = credit_reg - price_tbl[sel_item];
               dispense_next = 1'b1;
               item_next     = sel_item;
               reject_next   = nickel_in | dime_in;
            end else begin
               deny_next = sel_valid;
               // A simultaneous dime is always refused in favour of the nickel.
               if (nickel_in) begin
                  reject_next = dime_in | sum_n[CREDIT_W];
                  if (!sum_n[CREDIT_W])
                     credit_next = sum_n[CREDIT_W-1:0];
               end else if (dime_in) begin
                  reject_next = sum_d[CREDIT_W];
                  if (!sum_d[CREDIT_W])
                     credit_next = sum_d[CREDIT_W-1:0];
               end
            end
         end
         VEND, CHANGE: begin
            reject_next = nickel_in | dime_in;
            if (credit_reg != '0) begin
               state_next  = CHANGE;
               credit_next = credit_reg - ONE;
               nickel_next = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         credit_reg   <= '0;
         dispense_reg <= 1'b0;
         item_reg     <= 2'd0;
         nickel_reg   <= 1'b0;
         reject_reg   <= 1'b0;
         deny_reg     <= 1'b0;
         busy_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         credit_reg   <= credit_next;
         dispense_reg <= dispense_next;
         item_reg     <= item_next;
         nickel_reg   <= nickel_next;
         reject_reg   <= reject_next;
         deny_reg     <= deny_next;
         busy_reg     <= (state_next != IDLE);
      end
   end

   assign dispense      = dispense_reg;
   assign dispense_item = item_reg;
   assign nickel_out    = nickel_reg;
   assign coin_reject   = reject_reg;
   assign deny          = deny_reg;
   assign busy          = busy_reg;
   assign credit        = credit_reg;
   assign sold_out      = sold_out_int;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: each step queues the expected next-cycle outputs, then pops and checks them.
// Inventory steps run only when VEND_INVENTORY_EN is defined; the DUT is built with STOCK_INIT=1.
module tb_vend_controller;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       nickel_in = 1'b0, dime_in = 1'b0, cancel = 1'b0, sel_valid = 1'b0, restock = 1'b0;
   logic [1:0] sel_item = 2'd0;
   logic       dispense, nickel_out, coin_reject, deny, busy;
   logic [1:0] dispense_item;
   logic [5:0] credit;
   logic [3:0] sold_out;

   typedef struct {
      string       tag;
      logic [16:0] v;
   } exp_t;

   exp_t       sb [$];
   int         tests = 0;
   int         failed = 0;
   logic [3:0] so_exp = 4'b0000;

`ifdef VEND_INVENTORY_EN
   localparam bit INV = 1'b1;
`else
   localparam bit INV = 1'b0;
`endif

   vend_controller #(.STOCK_INIT(1)) dut (
      .clock(clock), .reset_n(reset_n), .nickel_in(nickel_in), .dime_in(dime_in),
      .cancel(cancel), .sel_valid(sel_valid), .sel_item(sel_item), .restock(restock),
      .dispense(dispense), .dispense_item(dispense_item), .nickel_out(nickel_out),
      .coin_reject(coin_reject), .deny(deny), .busy(busy), .credit(credit), .sold_out(sold_out)
   );

   always #5 clock = ~clock;

   task automatic drv(input logic n, input logic d, input logic c, input logic sv,
                      input logic [1:0] si, input logic rs);
      nickel_in = n; dime_in = d; cancel = c; sel_valid = sv; sel_item = si; restock = rs;
   endtask

   task automatic ex(input string tag, input logic e_disp, input logic [1:0] e_item,
                     input logic e_nout, input logic e_rej, input logic e_deny,
                     input logic e_busy, input logic [5:0] e_cred);
      exp_t        e;
      logic [16:0] obs;
      sb.push_back('{tag, {e_disp, e_item, e_nout, e_rej, e_deny, e_busy, e_cred, so_exp}});
      @(posedge clock);
      #1;
      drv(0, 0, 0, 0, 2'd0, 0);
      e   = sb.pop_front();
      obs = {dispense, dispense_item, nickel_out, coin_reject, deny, busy, credit, sold_out};
      tests++;
      assert (obs === e.v) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h (disp,item,nout,rej,deny,busy,credit,sold_out)",
                e.tag, obs, e.v);
      end
      $display("[TB] %s out=%h", e.tag, obs);
   endtask

   initial begin
      @(posedge clock);
      #1;
      ex("reset", 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;

      // Basic purchase with change.
      drv(1, 0, 0, 0, 2'd0, 0); ex("nickel", 0, 0, 0, 0, 0, 0, 1);
      drv(0, 1, 0, 0, 2'd0, 0); ex("dime_a", 0, 0, 0, 0, 0, 0, 3);
      drv(0, 1, 0, 0, 2'd0, 0); ex("dime_b", 0, 0, 0, 0, 0, 0, 5);
      if (INV) so_exp = 4'b0001;
      drv(0, 0, 0, 1, 2'd0, 0); ex("sel0_dispense", 1, 0, 0, 0, 0, 1, 2);
      ex("change1", 0, 0, 1, 0, 0, 1, 1);
      ex("change2", 0, 0, 1, 0, 0, 1, 0);
      ex("back_idle", 0, 0, 0, 0, 0, 0, 0);

      // Insufficient credit, then cancel with a dime during payout.
      drv(1, 0, 0, 0, 2'd0, 0); ex("n1", 0, 0, 0, 0, 0, 0, 1);
      drv(1, 0, 0, 0, 2'd0, 0); ex("n2", 0, 0, 0, 0, 0, 0, 2);
      drv(0, 0, 0, 1, 2'd1, 0); ex("sel1_deny", 0, 0, 0, 0, 1, 0, 2);
      drv(0, 0, 1, 0, 2'd0, 0); ex("cancel_n1", 0, 0, 1, 0, 0, 1, 1);
      drv(0, 1, 0, 0, 2'd0, 0); ex("dime_busy_rej", 0, 0, 1, 1, 0, 1, 0);
      ex("cancel_done", 0, 0, 0, 0, 0, 0, 0);

      // Nickel and dime together.
      drv(1, 1, 0, 0, 2'd0, 0); ex("both_coins", 0, 0, 0, 1, 0, 0, 1);
      drv(0, 0, 1, 0, 2'd0, 0); ex("cancel_one", 0, 0, 1, 0, 0, 1, 0);
      ex("cancel_one_done", 0, 0, 0, 0, 0, 0, 0);

      // Credit saturation boundary.
      for (int i = 1; i <= 31; i++) begin
         drv(0, 1, 0, 0, 2'd0, 0); ex($sformatf("fill_%0d", i), 0, 0, 0, 0, 0, 0, 6'(2 * i));
      end
      drv(0, 1, 0, 0, 2'd0, 0); ex("dime_ovf_rej", 0, 0, 0, 1, 0, 0, 62);
      drv(1, 0, 0, 0, 2'd0, 0); ex("nickel_to_63", 0, 0, 0, 0, 0, 0, 63);
      drv(1, 0, 0, 0, 2'd0, 0); ex("nickel_ovf_rej", 0, 0, 0, 1, 0, 0, 63);
      reset_n = 1'b0;
      so_exp  = 4'b0000;
      ex("reset_clear", 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;

`ifdef VEND_INVENTORY_EN
      drv(0, 1, 0, 0, 2'd0, 0); ex("inv_d1", 0, 0, 0, 0, 0, 0, 2);
      drv(0, 1, 0, 0, 2'd0, 0); ex("inv_d2", 0, 0, 0, 0, 0, 0, 4);
      drv(0, 1, 0, 0, 2'd0, 0); ex("inv_d3", 0, 0, 0, 0, 0, 0, 6);
      so_exp = 4'b0100;
      drv(0, 0, 0, 1, 2'd2, 0); ex("inv_buy2", 1, 2, 0, 0, 0, 1, 1);
      ex("inv_change", 0, 0, 1, 0, 0, 1, 0);
      ex("inv_idle", 0, 0, 0, 0, 0, 0, 0);
      drv(0, 1, 0, 0, 2'd0, 0); ex("inv_d4", 0, 0, 0, 0, 0, 0, 2);
      drv(0, 1, 0, 0, 2'd0, 0); ex("inv_d5", 0, 0, 0, 0, 0, 0, 4);
      drv(0, 1, 0, 0, 2'd0, 0); ex("inv_d6", 0, 0, 0, 0, 0, 0, 6);
      drv(0, 0, 0, 1, 2'd2, 0); ex("inv_soldout_deny", 0, 0, 0, 0, 1, 0, 6);
      so_exp = 4'b0000;
      drv(0, 0, 0, 0, 2'd0, 1); ex("inv_restock", 0, 0, 0, 0, 0, 0, 6);
      so_exp = 4'b0100;
      drv(0, 0, 0, 1, 2'd2, 0); ex("inv_rebuy2", 1, 2, 0, 0, 0, 1, 1);
      ex("inv_change2", 0, 0, 1, 0, 0, 1, 0);
      ex("inv_idle2", 0, 0, 0, 0, 0, 0, 0);
`endif

      // Reset during the second of four change nickels.
      drv(0, 1, 0, 0, 2'd0, 0); ex("r_d1", 0, 0, 0, 0, 0, 0, 2);
      drv(0, 1, 0, 0, 2'd0, 0); ex("r_d2", 0, 0, 0, 0, 0, 0, 4);
      drv(0, 1, 0, 0, 2'd0, 0); ex("r_d3", 0, 0, 0, 0, 0, 0, 6);
      drv(0, 1, 0, 0, 2'd0, 0); ex("r_d4", 0, 0, 0, 0, 0, 0, 8);
      if (INV) so_exp = so_exp | 4'b0010;
      drv(0, 0, 0, 1, 2'd1, 0); ex("r_buy1", 1, 1, 0, 0, 0, 1, 4);
      ex("r_change1", 0, 0, 1, 0, 0, 1, 3);
      ex("r_change2", 0, 0, 1, 0, 0, 1, 2);
      reset_n = 1'b0;
      so_exp  = 4'b0000;
      ex("r_reset", 0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      ex("r_idle", 0, 0, 0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 2'd0, 0); ex("r_recover", 0, 0, 0, 0, 0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
